alu_op_sequencer: RTL and testbench

- Front/back-end stage wrapped around alu_16bit.
- Accepts a 5-byte operation packet over an 8-bit valid/ready stream: command byte, then A (lo, hi), then B (lo, hi).
- Registers the operands and drives the 16-bit bit-sliced ALU for one cycle.
- Captures the result, carry-out and zero flag into an output register held under a valid/ready handshake. Includes an inter-byte timeout and command validation.

---
 rtl/alu_op_sequencer_pkg.sv | 27 ++
 rtl/alu_16bit.sv | 33 +++
 rtl/alu_op_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer: FSM states,
// command-byte field positions and packet length.
package alu_op_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GET_AL = 3'd1,
    GET_AH = 3'd2,
    GET_BL = 3'd3,
    GET_BH = 3'd4,
    EXEC   = 3'd5,
    RESP   = 3'd6
  } state_e;

  localparam int S_LSB     = 0;
  localparam int M_BIT     = 4;
  localparam int CIN_BIT   = 5;
  localparam int RSV_MSB   = 7;
  localparam int RSV_LSB   = 6;
  localparam int PKT_BYTES = 5;

  // True for the four operand-collection states, where the timeout runs.
  function automatic logic is_get_state(input state_e st);
    return (st == GET_AL) || (st == GET_AH) || (st == GET_BL) || (st == GET_BH);
  endfunction

endpackage

// File: rtl/alu_16bit.sv
// 16-bit bit-sliced ALU with a 74181-style function table.
// Each bit forms x = a | (s0 & b) | (s1 & ~b) and y = (s2 & a & ~b) | (s3 & a & b).
// Arithmetic (m=0): o = x + y + cin, cout is the carry out of bit 15.
// Logic (m=1):      o = ~(x ^ y), cout = 0.
module alu_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  input  logic        m,
  input  logic [3:0]  s,
  output logic [15:0] o,
  output logic        cout
);

  logic [15:0] x;
  logic [15:0] y;
  logic [15:0] h;
  logic [16:0] c;

  assign x = a | ({16{s[0]}} & b) | ({16{s[1]}} & ~b);
  assign y = ({16{s[2]}} & a & ~b) | ({16{s[3]}} & a & b);
  assign h = x ^ y;
  assign c[0] = cin;

  // Ripple carry through the per-bit slices.
  for (genvar i = 0; i < 16; i++) begin : g_slice
    assign c[i+1] = (x[i] & y[i]) | (h[i] & c[i]);
  end

  assign o    = m ? ~h : (h ^ c[15:0]);
  assign cout = m ? 1'b0 : c[16];

endmodule

// File: rtl/alu_op_sequencer.sv
// Collects a 5-byte operation packet (cmd, A lo/hi, B lo/hi) from a byte
// stream, runs it through alu_16bit for one cycle and holds the result
// under a valid/ready handshake. Aborts a packet on inter-byte timeout and
// rejects commands with reserved bits set.
//
// state  | meaning
// IDLE   | waiting for a command byte
// GET_AL | waiting for A[7:0]
// GET_AH | waiting for A[15:8]
// GET_BL | waiting for B[7:0]
// GET_BH | waiting for B[15:8]
// EXEC   | ALU inputs stable, result captured at end of cycle
// RESP   | result valid, waiting for out_ready
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic        out_cout,
  output logic        out_zero,
  output logic        err
);

  state_e             state_q, state_d;
  logic [15:0]        a_q, a_d;
  logic [15:0]        b_q, b_d;
  logic [3:0]         s_q, s_d;
  logic               m_q, m_d;
  logic               cin_q, cin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [15:0]        out_result_q, out_result_d;
  logic               out_cout_q, out_cout_d;
  logic               out_zero_q, out_zero_d;
  logic               err_q, err_d;

  logic               accept;
  logic [CNT_W-1:0]   cnt_inc;
  logic               timeout_hit;
  logic [15:0]        alu_o;
  logic               alu_cout;

  // ALU is fed only from registers so its inputs are steady during EXEC.
  alu_16bit u_alu (
    .a    (a_q),
    .b    (b_q),
    .cin  (cin_q),
    .m    (m_q),
    .s    (s_q),
    .o    (alu_o),
    .cout (alu_cout)
  );

  // Next-state, operand capture, timeout and output register computation.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    s_d          = s_q;
    m_d          = m_q;
    cin_d        = cin_q;
    cnt_d        = '0;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_cout_d   = out_cout_q;
    out_zero_d   = out_zero_q;
    err_d        = 1'b0;

    accept  = in_valid & in_ready_q;
    cnt_inc = cnt_q + CNT_W'(1);
    // A byte arriving on the terminal-count cycle wins over the abort.
    timeout_hit = (TIMEOUT != 0) && is_get_state(state_q) && !accept &&
                  (cnt_inc == CNT_W'(TIMEOUT));

    if (is_get_state(state_q) && !accept && (TIMEOUT != 0)) begin
      cnt_d = cnt_inc;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_data[RSV_MSB:RSV_LSB] != 2'b00) begin
            err_d = 1'b1;
          end else begin
            s_d     = in_data[S_LSB +: 4];
            m_d     = in_data[M_BIT];
            cin_d   = in_data[CIN_BIT];
            state_d = GET_AL;
          end
        end
      end
      GET_AL: begin
        if (accept) begin
          a_d[7:0] = in_data;
          state_d  = GET_AH;
        end
      end
      GET_AH: begin
        if (accept) begin
          a_d[15:8] = in_data;
          state_d   = GET_BL;
        end
      end
      GET_BL: begin
        if (accept) begin
          b_d[7:0] = in_data;
          state_d  = GET_BH;
        end
      end
      GET_BH: begin
        if (accept) begin
          b_d[15:8] = in_data;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        out_valid_d  = 1'b1;
        out_result_d = alu_o;
        out_cout_d   = alu_cout;
        out_zero_d   = (alu_o == 16'h0000);
        state_d      = RESP;
      end
      RESP: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (timeout_hit) begin
      state_d = IDLE;
      a_d     = '0;
      b_d     = '0;
      s_d     = '0;
      m_d     = 1'b0;
      cin_d   = 1'b0;
      cnt_d   = '0;
      err_d   = 1'b1;
    end

    in_ready_d = (state_d == IDLE) || is_get_state(state_d);
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      s_q          <= '0;
      m_q          <= 1'b0;
      cin_q        <= 1'b0;
      cnt_q        <= '0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_cout_q   <= 1'b0;
      out_zero_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      s_q          <= s_d;
      m_q          <= m_d;
      cin_q        <= cin_d;
      cnt_q        <= cnt_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_cout_q   <= out_cout_d;
      out_zero_q   <= out_zero_d;
      err_q        <= err_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_cout   = out_cout_q;
  assign out_zero   = out_zero_q;
  assign err        = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed and randomised checks for alu_op_sequencer with TIMEOUT=4.
module tb_alu_op_sequencer;
  import alu_op_sequencer_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_cout;
  logic        out_zero;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.TIMEOUT(TO), .CNT_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_cout   (out_cout),
    .out_zero   (out_zero),
    .err        (err)
  );

  // Golden ALU written directly from the function table: {cout, o}.
  function automatic logic [16:0] alu_model(input logic [3:0] s, input logic m, input logic cin,
                                            input logic [15:0] a, input logic [15:0] b);
    logic [15:0] p, q, f;
    p = '0; q = '0; f = '0;
    if (m) begin
      case (s)
        4'h0: f = ~a;
        4'h1: f = ~(a | b);
        4'h2: f = ~a & b;
        4'h3: f = 16'h0000;
        4'h4: f = ~(a & b);
        4'h5: f = ~b;
        4'h6: f = a ^ b;
        4'h7: f = a & ~b;
        4'h8: f = ~a | b;
        4'h9: f = ~(a ^ b);
        4'hA: f = b;
        4'hB: f = a & b;
        4'hC: f = 16'hFFFF;
        4'hD: f = a | ~b;
        4'hE: f = a | b;
        default: f = a;
      endcase
      return {1'b0, f};
    end
    case (s)
      4'h0: begin p = a;        q = 16'h0;  end
      4'h1: begin p = a | b;    q = 16'h0;  end
      4'h2: begin p = a | ~b;   q = 16'h0;  end
      4'h3: begin p = 16'hFFFF; q = 16'h0;  end
      4'h4: begin p = a;        q = a & ~b; end
      4'h5: begin p = a | b;    q = a & ~b; end
      4'h6: begin p = a;        q = ~b;     end
      4'h7: begin p = 16'hFFFF; q = a & ~b; end
      4'h8: begin p = a;        q = a & b;  end
      4'h9: begin p = a;        q = b;      end
      4'hA: begin p = a | ~b;   q = a & b;  end
      4'hB: begin p = 16'hFFFF; q = a & b;  end
      4'hC: begin p = a;        q = a;      end
      4'hD: begin p = a | b;    q = a;      end
      4'hE: begin p = a | ~b;   q = a;      end
      default: begin p = 16'hFFFF; q = a;   end
    endcase
    return {1'b0, p} + {1'b0, q} + {16'h0, cin};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, output bit ok);
    bit rdy;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 50; i++) begin
      rdy = in_ready;
      tick();
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL byte_accept: in_ready got 0 for 50 cycles, required 1");
    end
  endtask

  task automatic send_packet(input logic [7:0] cmd, input logic [15:0] a, input logic [15:0] b,
                             input int gap, input bit rnd_gap, output int err_hits);
    logic [7:0] pkt [PKT_BYTES];
    int g;
    bit ok;
    pkt[0] = cmd;
    pkt[1] = a[7:0];
    pkt[2] = a[15:8];
    pkt[3] = b[7:0];
    pkt[4] = b[15:8];
    err_hits = 0;
    for (int i = 0; i < PKT_BYTES; i++) begin
      if (i == 0) g = 0;
      else if (rnd_gap) g = int'($urandom_range(gap, 0));
      else g = gap;
      for (int j = 0; j < g; j++) begin
        tick();
        if (err) err_hits++;
      end
      send_byte(pkt[i], ok);
      if (err) err_hits++;
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_valid: out_valid got 0 for 10 cycles, required 1");
    end
  endtask

  task automatic handshake();
    bit v;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      v = out_valid;
      tick();
      if (v) break;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h16;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({in_ready, out_valid, err, out_cout, out_zero} !== 5'b0 || out_result !== 16'h0) begin
        errors++;
        $display("FAIL reset_outputs: got rdy=%b ov=%b err=%b cout=%b zero=%b res=%h, required all 0",
                 in_ready, out_valid, err, out_cout, out_zero, out_result);
      end
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_logic_xor();
    int eh;
    out_ready = 1'b0;
    send_packet(8'h16, 16'hF0F0, 16'h0FF0, 0, 1'b0, eh);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL xor_early_valid: got %b required 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL xor_latency: out_valid got %b required 1", out_valid);
    end
    checks++;
    if (out_result !== 16'hFF00 || out_zero !== 1'b0 || out_cout !== 1'b0) begin
      errors++;
      $display("FAIL xor_result: got res=%h zero=%b cout=%b required res=ff00 zero=0 cout=0",
               out_result, out_zero, out_cout);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL xor_handshake: got ov=%b rdy=%b required ov=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_zero_backpressure();
    int eh;
    bit ok;
    out_ready = 1'b0;
    send_packet(8'h16, 16'h1234, 16'h1234, 0, 1'b0, eh);
    wait_valid(ok);
    checks++;
    if (out_result !== 16'h0000 || out_zero !== 1'b1) begin
      errors++;
      $display("FAIL zero_flag: got res=%h zero=%b required res=0000 zero=1", out_result, out_zero);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_result !== 16'h0 || out_zero !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: got ov=%b res=%h zero=%b rdy=%b required ov=1 res=0000 zero=1 rdy=0",
                 i, out_valid, out_result, out_zero, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release: out_valid got %b required 0", out_valid);
    end
  endtask

  task automatic test_bad_cmd();
    int eh;
    bit ok;
    bit rdy;
    in_valid = 1'b1;
    in_data = 8'h86;
    rdy = in_ready;
    tick();
    in_valid = 1'b0;
    checks++;
    if (rdy !== 1'b1 || err !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bad_cmd_err: got rdy_before=%b err=%b rdy=%b required 1 1 1", rdy, err, in_ready);
    end
    tick();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL bad_cmd_pulse_width: err got %b required 0", err);
    end
    out_ready = 1'b1;
    send_packet(8'h29, 16'h1234, 16'h4321, 0, 1'b0, eh);
    wait_valid(ok);
    checks++;
    if (out_result !== 16'h5556 || out_cout !== 1'b0 || eh != 0) begin
      errors++;
      $display("FAIL bad_cmd_followup: got res=%h cout=%b errs=%0d required res=5556 cout=0 errs=0",
               out_result, out_cout, eh);
    end
    handshake();
  endtask

  task automatic test_timeout();
    int eh;
    bit ok;
    send_byte(8'h16, ok);
    send_byte(8'hAA, ok);
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (err !== (i == 4)) begin
        errors++;
        $display("FAIL timeout_err_idle%0d: err got %b required %b", i, err, (i == 4));
      end
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_ready: got %b required 1", in_ready);
    end
    tick();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse_width: err got %b required 0", err);
    end
    send_packet(8'h16, 16'h00FF, 16'h0F0F, 0, 1'b0, eh);
    wait_valid(ok);
    checks++;
    if (out_result !== 16'h0FF0 || eh != 0) begin
      errors++;
      $display("FAIL timeout_recover: got res=%h errs=%0d required res=0ff0 errs=0", out_result, eh);
    end
    handshake();
    send_packet(8'h16, 16'h00FF, 16'h0F0F, TO - 1, 1'b0, eh);
    wait_valid(ok);
    checks++;
    if (out_result !== 16'h0FF0 || eh != 0) begin
      errors++;
      $display("FAIL timeout_gap3: got res=%h errs=%0d required res=0ff0 errs=0", out_result, eh);
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    logic [7:0]  cmd_v [5] = '{8'h09, 8'h06, 8'h26, 8'h2C, 8'h0F};
    logic [15:0] a_v   [5] = '{16'hFFFF, 16'h0005, 16'h0005, 16'h8000, 16'h0000};
    logic [15:0] b_v   [5] = '{16'h0001, 16'h0003, 16'h0003, 16'h1111, 16'h2222};
    logic [15:0] r_v   [5] = '{16'h0000, 16'h0001, 16'h0002, 16'h0001, 16'hFFFF};
    logic        c_v   [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int eh;
    bit ok;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_packet(cmd_v[i], a_v[i], b_v[i], 0, 1'b0, eh);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_result !== r_v[i] || out_cout !== c_v[i] ||
          out_zero !== (r_v[i] == 16'h0)) begin
        errors++;
        $display("FAIL b2b_result[%0d]: got ov=%b res=%h cout=%b zero=%b required ov=1 res=%h cout=%b zero=%b",
                 i, out_valid, out_result, out_cout, out_zero, r_v[i], c_v[i], (r_v[i] == 16'h0));
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_turnaround[%0d]: got ov=%b rdy=%b required ov=0 rdy=1", i, out_valid, in_ready);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_sweep();
    logic [7:0]  cmd;
    logic [15:0] a, b;
    logic [16:0] exp_v;
    int eh;
    bit ok, r, v, done;
    for (int n = 0; n < 200; n++) begin
      cmd = {2'b00, 6'($urandom)};
      a = 16'($urandom);
      b = 16'($urandom);
      exp_v = alu_model(cmd[3:0], cmd[4], cmd[5], a, b);
      send_packet(cmd, a, b, TO - 1, 1'b1, eh);
      wait_valid(ok);
      checks++;
      if ({out_cout, out_result} !== exp_v || out_zero !== (exp_v[15:0] == 16'h0) || eh != 0) begin
        errors++;
        $display("FAIL sweep[%0d] cmd=%h a=%h b=%h: got cout=%b res=%h zero=%b errs=%0d required cout=%b res=%h",
                 n, cmd, a, b, out_cout, out_result, out_zero, eh, exp_v[16], exp_v[15:0]);
      end
      done = 1'b0;
      for (int i = 0; i < 40; i++) begin
        out_ready = (i >= 20) ? 1'b1 : 1'($urandom_range(1, 0));
        r = out_ready;
        v = out_valid;
        tick();
        if (r && v) begin
          done = 1'b1;
          break;
        end
      end
      out_ready = 1'b0;
      if (!done) begin
        checks++;
        errors++;
        $display("FAIL sweep_handshake[%0d]: out_valid never accepted, required handshake", n);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    out_ready = 1'b0;
    test_reset();
    test_logic_xor();
    test_zero_backpressure();
    test_bad_cmd();
    test_timeout();
    test_back_to_back();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
